// File: rtl/dma_copy.sv
// Word-granular memory-to-memory copy engine; optional fill mode under DMA_FILL_EN.
// Latency: first request the cycle after START; 2 cycles/word copy, 1 cycle/word fill (zero-wait).
// Backpressure: initiator requests are held stable until ready_in; responder is zero-wait.
module dma_copy #(
    parameter int LEN_BITS = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address_in,
    input  logic        sel_in,
    input  logic        read_in,
    output logic [31:0] read_value_out,
    input  logic [3:0]  write_mask_in,
    input  logic [31:0] write_value_in,
    output logic        ready_out,
    output logic [31:0] address_out,
    output logic        read_out,
    output logic        write_out,
    output logic [3:0]  write_mask_out,
    output logic [31:0] write_value_out,
    input  logic [31:0] read_value_in,
    input  logic        ready_in,
    input  logic        fault_in,
    output logic        irq_out
);

    typedef enum logic [1:0] {IDLE, RD, WR} state_t;

    state_t              state_q, state_d;
    logic [31:0]         src_q, dst_q, buf_q;
    logic [LEN_BITS-1:0] len_q;
    logic                done_q, err_q;
    logic                fill_mode;
`ifdef DMA_FILL_EN
    logic [31:0]         fill_q;
    logic                fill_mode_q;
    assign fill_mode = fill_mode_q;
`else
    assign fill_mode = 1'b0;
`endif

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] mask);
        logic [31:0] r;
        for (int b = 0; b < 4; b++)
            r[b*8 +: 8] = mask[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
        return r;
    endfunction

    logic [2:0]  reg_idx;
    logic        idle, wr_any, wr_ctrl, start_req, beat_ok, beat_fault, last_word;
    logic        done_set, err_set, done_clr, err_clr;
    logic [31:0] len_ext, len_merged;

    assign reg_idx    = address_in[4:2];
    assign idle       = (state_q == IDLE);
    assign wr_any     = sel_in && (write_mask_in != 4'b0000) && idle;
    assign wr_ctrl    = sel_in && write_mask_in[0] && (reg_idx == 3'd3);
    assign start_req  = wr_ctrl && write_value_in[0] && idle;
    assign beat_ok    = ready_in && !fault_in;
    assign beat_fault = ready_in && fault_in;
    assign last_word  = (len_q == LEN_BITS'(1));
    assign len_ext    = {{(32-LEN_BITS){1'b0}}, len_q};
    assign len_merged = merge(len_ext, write_value_in, write_mask_in);

    // Hardware set beats a software clear landing on the same edge.
    assign done_set = ((state_q == WR) && beat_ok && last_word) ||
                      (start_req && (len_q == '0));
    assign err_set  = !idle && beat_fault;
    assign done_clr = wr_ctrl && write_value_in[2];
    assign err_clr  = wr_ctrl && write_value_in[3];

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_req && (len_q != '0)) begin
`ifdef DMA_FILL_EN
                    state_d = write_value_in[4] ? WR : RD;
`else
                    state_d = RD;
`endif
                end
            end
            RD: begin
                if (ready_in)
                    state_d = fault_in ? IDLE : WR;
            end
            WR: begin
                if (ready_in) begin
                    if (fault_in || last_word)
                        state_d = IDLE;
                    else
                        state_d = fill_mode ? WR : RD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src_q  <= '0;
            dst_q  <= '0;
            len_q  <= '0;
            buf_q  <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
`ifdef DMA_FILL_EN
            fill_q      <= '0;
            fill_mode_q <= 1'b0;
`endif
        end else begin
            if (wr_any && reg_idx == 3'd0)
                src_q <= merge(src_q, write_value_in, write_mask_in) & 32'hFFFF_FFFC;
            if (wr_any && reg_idx == 3'd1)
                dst_q <= merge(dst_q, write_value_in, write_mask_in) & 32'hFFFF_FFFC;
            if (wr_any && reg_idx == 3'd2)
                len_q <= len_merged[LEN_BITS-1:0];
`ifdef DMA_FILL_EN
            if (wr_any && reg_idx == 3'd4)
                fill_q <= merge(fill_q, write_value_in, write_mask_in);
            if (wr_ctrl && idle)
                fill_mode_q <= write_value_in[4];
`endif
            if (state_q == RD && beat_ok)
                buf_q <= read_value_in;
            if (state_q == WR && beat_ok) begin
                if (!fill_mode)
                    src_q <= src_q + 32'd4;
                dst_q <= dst_q + 32'd4;
                len_q <= len_q - LEN_BITS'(1);
            end
            done_q <= done_set || (done_q && !done_clr);
            err_q  <= err_set  || (err_q  && !err_clr);
        end
    end

    logic [31:0] rdata;
    always_comb begin
        rdata = '0;
        case (reg_idx)
            3'd0: rdata = src_q;
            3'd1: rdata = dst_q;
            3'd2: rdata = len_ext;
            3'd3: rdata = {27'b0, fill_mode, err_q, done_q, !idle, 1'b0};
`ifdef DMA_FILL_EN
            3'd4: rdata = fill_q;
`endif
            default: rdata = '0;
        endcase
    end

    logic [31:0] wdata;
`ifdef DMA_FILL_EN
    assign wdata = fill_mode ? fill_q : buf_q;
`else
    assign wdata = buf_q;
`endif

    assign read_value_out  = sel_in ? rdata : 32'b0;
    assign ready_out       = sel_in;
    assign read_out        = (state_q == RD);
    assign write_out       = (state_q == WR);
    assign address_out     = read_out ? src_q : (write_out ? dst_q : 32'b0);
    assign write_mask_out  = write_out ? 4'b1111 : 4'b0000;
    assign write_value_out = write_out ? wdata : 32'b0;
    assign irq_out         = done_q | err_q;

    logic unused_bits;
    assign unused_bits = ^{address_in[31:5], address_in[1:0], read_in, len_merged};

endmodule
